memory_access: RTL and testbench
================================

// Module: memory_access
// PURPOSE
//  Memory stage of the RISC-V pipeline, directly downstream of the execution stage.
//  - Consumes the ALU result (address or pass-through value), store data and rd.
//  - Runs load/store transactions on a req/gnt/rvalid data-memory bus.
//  - Handles byte-lane steering and load sign/zero extension.
//  - Stalls upstream while a transaction is in flight; presents a registered result to writeback.
// PARAMETERS
//  WAIT_LIMIT  255  max cycles spent in REQ or WAIT_R before the access aborts with bus_error
// PORTS
//  clk                         in   1   clock, rising edge
//  rst                         in   1   asynchronous reset, active-low
//  valid_from_execution        in   1   upstream instruction valid; inputs held stable while stall high
//  alu_result_from_execution   in   32  memory address, or result for non-memory ops
//  read_data_2_from_execution  in   32  store data
//  immed_11_7_from_execution   in   5   destination register rd
//  mem_read_control            in   1   load
//  mem_write_control           in   1   store
//  mem_size_control            in   2   00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  mem_unsigned_control        in   1   1 = zero-extend loads (LBU/LHU)
//  reg_write_control           in   1   instruction writes rd
//  dmem_req                    out  1   bus request
//  dmem_we                     out  1   1 = write
//  dmem_addr                   out  32  word-aligned address ({addr[31:2],2'b00})
//  dmem_be                     out  4   byte enables
//  dmem_wdata                  out  32  lane-replicated store data
//  dmem_gnt                    in   1   request accepted
//  dmem_rvalid                 in   1   read data valid
//  dmem_rdata                  in   32  read data
//  stall_from_memory           out  1   upstream must hold
//  valid_from_memory           out  1   one-cycle completion pulse
//  result_from_memory          out  32  load data or pass-through ALU result
//  rd_from_memory              out  5   destination register
//  reg_write_from_memory       out  1   writeback enable; qualified by valid
//  misaligned_from_memory      out  1   completed access was misaligned
//  bus_error_from_memory       out  1   completed access timed out
// BEHAVIOUR
//  Reset (rst=0):
//   - State IDLE; wait counter 0.
//   - Every output 0 immediately (asynchronous); dmem_req drops mid-transaction.
//   - An rvalid/gnt arriving after reset is ignored.
//  FSM states: IDLE, REQ, WAIT_R. Inputs are captured into internal registers on accept.
//  IDLE, valid=1, no mem op:
//   - Next edge: valid pulse, result=alu_result, rd and reg_write passed through.
//   - Latency 1; stall stays low.
//  IDLE, valid=1, mem op:
//   - Misaligned (half with a[0]=1, word with a[1:0]!=0):
//     - No bus request; next edge: valid pulse, misaligned=1, reg_write=0.
//   - Aligned:
//     - stall asserted combinationally this cycle.
//     - Capture operands; go to REQ.
//  Read priority: mem_read and mem_write both set -> executes as a load.
//  REQ:
//   - dmem_req=1; addr/we/be/wdata stable until gnt.
//   - gnt on a store -> next edge: valid pulse, reg_write=0, go to IDLE.
//     - Store latency is 2 cycles minimum.
//   - gnt on a load -> go to WAIT_R.
//  WAIT_R:
//   - dmem_req=0; rvalid is sampled only in this state, at least one cycle after gnt.
//   - On rvalid -> next edge: extracted result, valid pulse, go to IDLE.
//     - Load latency is 3 cycles minimum.
//  Stall: high whenever state != IDLE, plus the accept cycle of an aligned mem op.
//   - Drops in the cycle the completion is registered.
//  Byte enables:
//   - byte: 4'b0001 << a[1:0]
//   - half: 4'b0011 << {a[1],1'b0}
//   - word: 4'b1111
//  Write data: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
//  Load extraction: select the lane by a[1:0]; sign-extend bit 7/15 unless unsigned.
//  Timeout:
//   - The counter clears on entry to REQ and counts every cycle in REQ/WAIT_R.
//   - At WAIT_LIMIT: abort (dmem_req=0), valid pulse, bus_error=1, reg_write=0, go to IDLE.
//  Flags: misaligned/bus_error are valid with the pulse and are cleared by the next completion.
//   - result/rd hold their value between pulses.
// TESTING
//  1 Pass-through: valid, no mem op, alu=0x12345678, rd=5
//    -> next cycle valid=1, result=0x12345678, rd=5, stall never high.
//  2 SB addr=0x103, data=0xAABBCCDD, gnt 2 cycles late
//    -> addr 0x100, be=4'b1000, wdata 0xDDDDDDDD, we=1; valid pulse cycle after gnt, reg_write=0.
//  3 LH addr=0x202, rdata=0x80017FFF -> result 0xFFFF8001; LHU -> 0x00008001; stall until completion.
//  4 LW addr=0x006 -> no dmem_req, valid next cycle, misaligned=1, reg_write=0.
//  5 LW with gnt held 0 -> after WAIT_LIMIT cycles bus_error=1, valid pulse, dmem_req=0, FSM IDLE.
//  6 rst=0 in WAIT_R -> dmem_req/stall/valid 0 at once; rvalid after reset release produces no pulse.

Source files
------------

// File: rtl/memory_access.sv
// Memory stage: runs load/store transactions on a req/gnt/rvalid bus, steers byte lanes,
// extends load data and presents a registered one-cycle completion to writeback.
module memory_access #(
    parameter int WAIT_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_from_execution,
    input  logic [31:0] alu_result_from_execution,
    input  logic [31:0] read_data_2_from_execution,
    input  logic [4:0]  immed_11_7_from_execution,
    input  logic        mem_read_control,
    input  logic        mem_write_control,
    input  logic [1:0]  mem_size_control,
    input  logic        mem_unsigned_control,
    input  logic        reg_write_control,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        stall_from_memory,
    output logic        valid_from_memory,
    output logic [31:0] result_from_memory,
    output logic [4:0]  rd_from_memory,
    output logic        reg_write_from_memory,
    output logic        misaligned_from_memory,
    output logic        bus_error_from_memory
);

    localparam int CW = $clog2(WAIT_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  be_reg;
    logic        we_reg, uns_reg, rw_reg;
    logic [1:0]  size_reg;
    logic [4:0]  rd_reg;

    logic        valid_reg, valid_next;
    logic [31:0] result_reg, result_next;
    logic [4:0]  rd_out_reg, rd_out_next;
    logic        rw_out_reg, rw_out_next;
    logic        mis_reg, mis_next;
    logic        berr_reg, berr_next;

    logic        capture, stall, mem_op, addr_misaligned, timeout;
    logic [3:0]  be_in;
    logic [31:0] wdata_in, lane_data, load_data;

    assign mem_op  = mem_read_control | mem_write_control;
    assign timeout = (cnt_reg == CW'(WAIT_LIMIT - 1));

    always_comb begin
        addr_misaligned = 1'b0;
        be_in           = 4'b1111;
        case (mem_size_control)
            2'b00: be_in = 4'b0001 << alu_result_from_execution[1:0];
            2'b01: begin
                be_in           = 4'b0011 << {alu_result_from_execution[1], 1'b0};
                addr_misaligned = alu_result_from_execution[0];
            end
            default: addr_misaligned = |alu_result_from_execution[1:0];
        endcase
    end

    // Each byte lane carries the store byte/halfword replicated so the bus can pick any lane.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign wdata_in[8*gi +: 8] =
            (mem_size_control == 2'b00) ? read_data_2_from_execution[7:0] :
            (mem_size_control == 2'b01) ? read_data_2_from_execution[8*(gi%2) +: 8] :
                                          read_data_2_from_execution[8*gi +: 8];
    end

    assign lane_data = dmem_rdata >> {addr_reg[1:0], 3'b000};

    always_comb begin
        case (size_reg)
            2'b00:   load_data = {{24{~uns_reg & lane_data[7]}}, lane_data[7:0]};
            2'b01:   load_data = {{16{~uns_reg & lane_data[15]}}, lane_data[15:0]};
            default: load_data = dmem_rdata;
        endcase
    end

    // Stall falls in the cycle a completion is decided so upstream advances on that edge.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        capture     = 1'b0;
        stall       = 1'b0;
        valid_next  = 1'b0;
        result_next = result_reg;
        rd_out_next = rd_out_reg;
        rw_out_next = 1'b0;
        mis_next    = mis_reg;
        berr_next   = berr_reg;
        case (state_reg)
            IDLE: begin
                if (valid_from_execution) begin
                    if (!mem_op || addr_misaligned) begin
                        valid_next  = 1'b1;
                        result_next = alu_result_from_execution;
                        rd_out_next = immed_11_7_from_execution;
                        rw_out_next = reg_write_control & ~mem_op;
                        mis_next    = mem_op;
                        berr_next   = 1'b0;
                    end else begin
                        stall      = 1'b1;
                        capture    = 1'b1;
                        cnt_next   = '0;
                        state_next = REQ;
                    end
                end
            end
            REQ, WAIT_R: begin
                stall    = 1'b1;
                cnt_next = cnt_reg + CW'(1);
                if (state_reg == REQ && dmem_gnt && !we_reg) begin
                    state_next = WAIT_R;
                end else if ((state_reg == REQ && dmem_gnt) ||
                             (state_reg == WAIT_R && dmem_rvalid)) begin
                    stall       = 1'b0;
                    valid_next  = 1'b1;
                    rd_out_next = rd_reg;
                    rw_out_next = rw_reg & ~we_reg;
                    mis_next    = 1'b0;
                    berr_next   = 1'b0;
                    if (!we_reg)
                        result_next = load_data;
                    state_next  = IDLE;
                end else if (timeout) begin
                    stall       = 1'b0;
                    valid_next  = 1'b1;
                    rd_out_next = rd_reg;
                    mis_next    = 1'b0;
                    berr_next   = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            addr_reg   <= '0;
            wdata_reg  <= '0;
            be_reg     <= '0;
            we_reg     <= 1'b0;
            uns_reg    <= 1'b0;
            rw_reg     <= 1'b0;
            size_reg   <= '0;
            rd_reg     <= '0;
            valid_reg  <= 1'b0;
            result_reg <= '0;
            rd_out_reg <= '0;
            rw_out_reg <= 1'b0;
            mis_reg    <= 1'b0;
            berr_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            valid_reg  <= valid_next;
            result_reg <= result_next;
            rd_out_reg <= rd_out_next;
            rw_out_reg <= rw_out_next;
            mis_reg    <= mis_next;
            berr_reg   <= berr_next;
            if (capture) begin
                addr_reg  <= alu_result_from_execution;
                wdata_reg <= wdata_in;
                be_reg    <= be_in;
                we_reg    <= mem_write_control & ~mem_read_control;
                uns_reg   <= mem_unsigned_control;
                rw_reg    <= reg_write_control;
                size_reg  <= mem_size_control;
                rd_reg    <= immed_11_7_from_execution;
            end
        end
    end

    assign dmem_req               = (state_reg == REQ);
    assign dmem_we                = we_reg;
    assign dmem_addr              = {addr_reg[31:2], 2'b00};
    assign dmem_be                = be_reg;
    assign dmem_wdata             = wdata_reg;
    assign stall_from_memory      = stall;
    assign valid_from_memory      = valid_reg;
    assign result_from_memory     = result_reg;
    assign rd_from_memory         = rd_out_reg;
    assign reg_write_from_memory  = rw_out_reg;
    assign misaligned_from_memory = mis_reg;
    assign bus_error_from_memory  = berr_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: a bus responder, a completion scoreboard and
// immediate-assertion checks on bus traffic, stall behaviour and writeback results.
module tb_memory_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid_from_execution = 1'b0;
    logic [31:0] alu_result_from_execution = '0;
    logic [31:0] read_data_2_from_execution = '0;
    logic [4:0]  immed_11_7_from_execution = '0;
    logic        mem_read_control = 1'b0;
    logic        mem_write_control = 1'b0;
    logic [1:0]  mem_size_control = '0;
    logic        mem_unsigned_control = 1'b0;
    logic        reg_write_control = 1'b0;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_from_memory, valid_from_memory;
    logic [31:0] result_from_memory;
    logic [4:0]  rd_from_memory;
    logic        reg_write_from_memory, misaligned_from_memory, bus_error_from_memory;

    memory_access dut (
        .clk                        (clk),
        .rst                        (rst),
        .valid_from_execution       (valid_from_execution),
        .alu_result_from_execution  (alu_result_from_execution),
        .read_data_2_from_execution (read_data_2_from_execution),
        .immed_11_7_from_execution  (immed_11_7_from_execution),
        .mem_read_control           (mem_read_control),
        .mem_write_control          (mem_write_control),
        .mem_size_control           (mem_size_control),
        .mem_unsigned_control       (mem_unsigned_control),
        .reg_write_control          (reg_write_control),
        .dmem_req                   (dmem_req),
        .dmem_we                    (dmem_we),
        .dmem_addr                  (dmem_addr),
        .dmem_be                    (dmem_be),
        .dmem_wdata                 (dmem_wdata),
        .dmem_gnt                   (dmem_gnt),
        .dmem_rvalid                (dmem_rvalid),
        .dmem_rdata                 (dmem_rdata),
        .stall_from_memory          (stall_from_memory),
        .valid_from_memory          (valid_from_memory),
        .result_from_memory         (result_from_memory),
        .rd_from_memory             (rd_from_memory),
        .reg_write_from_memory      (reg_write_from_memory),
        .misaligned_from_memory     (misaligned_from_memory),
        .bus_error_from_memory      (bus_error_from_memory)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        rw, mis, berr, chk;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   passed = 0;
    int   failed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] res, input logic [4:0] rd,
                            input logic rw, input logic mis, input logic berr, input logic chk);
        exp_t e;
        e.result = res; e.rd = rd; e.rw = rw; e.mis = mis; e.berr = berr; e.chk = chk;
        sb.push_back(e);
    endtask

    // Bus responder: grants after gnt_delay request cycles, returns rvalid rvalid_delay cycles later.
    int          gnt_delay = 0, rvalid_delay = 0, reqcnt = 0, rcnt = 0;
    logic        gnt_never = 1'b0, pend = 1'b0;
    logic [31:0] obs_addr = '0, obs_wdata = '0;
    logic [3:0]  obs_be = '0;
    logic        obs_we = 1'b0;

    always @(negedge clk) begin
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        if (pend) begin
            if (rcnt == rvalid_delay) begin
                dmem_rvalid = 1'b1;
                pend        = 1'b0;
            end else rcnt++;
        end
        if (dmem_req && !gnt_never) begin
            if (reqcnt == gnt_delay) begin
                dmem_gnt  = 1'b1;
                reqcnt    = 0;
                obs_addr  = dmem_addr;
                obs_be    = dmem_be;
                obs_wdata = dmem_wdata;
                obs_we    = dmem_we;
                if (!dmem_we) begin
                    pend = 1'b1;
                    rcnt = 0;
                end
            end else reqcnt++;
        end else reqcnt = 0;
    end

    // Completion monitor: every pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst === 1'b1 && valid_from_memory === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("wb_reg_write", reg_write_from_memory, mon_e.rw);
                check("wb_misaligned", misaligned_from_memory, mon_e.mis);
                check("wb_bus_error", bus_error_from_memory, mon_e.berr);
                if (mon_e.chk) begin
                    check("wb_result", result_from_memory, mon_e.result);
                    check("wb_rd", rd_from_memory, 32'(mon_e.rd));
                end
                $display("completion result=%h rd=%0d rw=%b mis=%b berr=%b", result_from_memory,
                         rd_from_memory, reg_write_from_memory, misaligned_from_memory,
                         bus_error_from_memory);
            end
        end
    end

    // Upstream model: present an instruction and hold it while stall is high.
    task automatic run_op(input logic [31:0] alu, input logic [31:0] d, input logic [4:0] rd,
                          input logic mr, input logic mw, input logic [1:0] sz, input logic un,
                          input logic rwc, output int stall_cyc, output int req_cyc);
        logic s;
        @(posedge clk);
        #1;
        alu_result_from_execution  = alu;
        read_data_2_from_execution = d;
        immed_11_7_from_execution  = rd;
        mem_read_control           = mr;
        mem_write_control          = mw;
        mem_size_control           = sz;
        mem_unsigned_control       = un;
        reg_write_control          = rwc;
        valid_from_execution       = 1'b1;
        stall_cyc = 0;
        req_cyc   = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            #1;
            s = stall_from_memory;
            if (s) stall_cyc++;
            if (dmem_req) req_cyc++;
            @(posedge clk);
            if (!s) break;
            if (i == 599) check("driver_cycle_budget", 32'd1, 32'd0);
        end
        #1;
        valid_from_execution = 1'b0;
        mem_read_control     = 1'b0;
        mem_write_control    = 1'b0;
    endtask

    task automatic expect_pulse(input string tag);
        @(negedge clk);
        #1;
        check(tag, valid_from_memory, 1'b1);
    endtask

    int sc, rc;

    initial begin
        #2 rst = 1'b0;
        #1;
        check("rst_valid", valid_from_memory, 1'b0);
        check("rst_stall", stall_from_memory, 1'b0);
        check("rst_req", dmem_req, 1'b0);
        check("rst_result", result_from_memory, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Pass-through
        push_exp(32'h12345678, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h12345678, 32'h0, 5'd5, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, sc, rc);
        check("pt_stall_cycles", sc, 0);
        expect_pulse("pt_pulse");

        // SB with grant two cycles late
        gnt_delay = 2;
        push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'h103, 32'hAABBCCDD, 5'd9, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, sc, rc);
        check("sb_addr", obs_addr, 32'h100);
        check("sb_be", obs_be, 4'b1000);
        check("sb_wdata", obs_wdata, 32'hDDDDDDDD);
        check("sb_we", obs_we, 1'b1);
        check("sb_stall_cycles", sc, 3);
        expect_pulse("sb_pulse");

        // SH upper half
        gnt_delay = 0;
        push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op(32'h102, 32'h1234ABCD, 5'd9, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, sc, rc);
        check("sh_be", obs_be, 4'b1100);
        check("sh_wdata", obs_wdata, 32'hABCDABCD);
        expect_pulse("sh_pulse");

        // Loads with lane extraction and extension
        dmem_rdata = 32'h80017FFF;
        push_exp(32'hFFFF8001, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h202, 32'h0, 5'd7, 1'b1, 1'b0, 2'b01, 1'b0, 1'b1, sc, rc);
        check("lh_addr", obs_addr, 32'h200);
        check("lh_be", obs_be, 4'b1100);
        check("lh_stall_cycles", sc, 2);
        check("lh_req_cycles", rc, 1);
        expect_pulse("lh_pulse");

        push_exp(32'h00008001, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h202, 32'h0, 5'd8, 1'b1, 1'b0, 2'b01, 1'b1, 1'b1, sc, rc);
        expect_pulse("lhu_pulse");

        push_exp(32'hFFFFFF80, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h203, 32'h0, 5'd10, 1'b1, 1'b0, 2'b00, 1'b0, 1'b1, sc, rc);
        check("lb_be", obs_be, 4'b1000);
        expect_pulse("lb_pulse");

        push_exp(32'h0000007F, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h201, 32'h0, 5'd11, 1'b1, 1'b0, 2'b00, 1'b1, 1'b1, sc, rc);
        expect_pulse("lbu_pulse");

        // Load and store both set executes as a load; slow rvalid
        rvalid_delay = 2;
        push_exp(32'h80017FFF, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op(32'h204, 32'h55555555, 5'd12, 1'b1, 1'b1, 2'b10, 1'b0, 1'b1, sc, rc);
        check("lw_prio_we", obs_we, 1'b0);
        check("lw_prio_be", obs_be, 4'b1111);
        check("lw_stall_cycles", sc, 4);
        expect_pulse("lw_pulse");
        rvalid_delay = 0;

        // Misaligned word load
        push_exp(32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        run_op(32'h006, 32'h0, 5'd13, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, sc, rc);
        check("mis_stall_cycles", sc, 0);
        check("mis_req_cycles", rc, 0);
        expect_pulse("mis_pulse");

        // Timeout with no grant
        gnt_never = 1'b1;
        push_exp(32'h0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        run_op(32'h40, 32'h0, 5'd3, 1'b1, 1'b0, 2'b10, 1'b0, 1'b1, sc, rc);
        check("to_req_cycles", rc, 255);
        expect_pulse("to_pulse");
        check("to_req_after", dmem_req, 1'b0);
        gnt_never = 1'b0;

        // Back in IDLE: pass-through again clears the error flag
        push_exp(32'hCAFEBABE, 5'd1, 1'b0, 1'b0, 1'b0, 1'b1);
        run_op(32'hCAFEBABE, 32'h0, 5'd1, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, sc, rc);
        check("post_to_stall_cycles", sc, 0);
        expect_pulse("post_to_pulse");

        // Reset while waiting for rvalid; the late rvalid must not produce a pulse
        rvalid_delay = 6;
        @(posedge clk);
        #1;
        alu_result_from_execution = 32'h300;
        mem_read_control          = 1'b1;
        mem_size_control          = 2'b10;
        reg_write_control         = 1'b1;
        valid_from_execution      = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rw_stall_pre", stall_from_memory, 1'b1);
        rst                  = 1'b0;
        valid_from_execution = 1'b0;
        mem_read_control     = 1'b0;
        #1;
        check("rw_rst_req", dmem_req, 1'b0);
        check("rw_rst_stall", stall_from_memory, 1'b0);
        check("rw_rst_valid", valid_from_memory, 1'b0);
        check("rw_rst_result", result_from_memory, 32'h0);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("rw_idle_stall", stall_from_memory, 1'b0);
        rvalid_delay = 0;

        // Reset while requesting drops dmem_req at once
        gnt_never = 1'b1;
        alu_result_from_execution = 32'h310;
        mem_read_control          = 1'b1;
        valid_from_execution      = 1'b1;
        @(posedge clk);
        #1;
        valid_from_execution = 1'b0;
        mem_read_control     = 1'b0;
        check("rq_req_pre", dmem_req, 1'b1);
        rst = 1'b0;
        #1;
        check("rq_rst_req", dmem_req, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        gnt_never = 1'b0;

        repeat (3) @(posedge clk);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
